// File: rtl/farc_addsub_seq.sv
// -----------------------------------------------------------------------------
// farc_addsub_seq
// Sequencing stage around a combinational ripple-carry adder/subtractor.
// A request (A, B, format, add/sub, tag) is accepted over a valid/ready
// handshake and its fields are registered onto the adder input ports. After
// ADD_LAT settle cycles the adder sum/carry are captured, overflow and zero
// flags are derived, and the result is held on a valid/ready output
// handshake until consumed.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid / req_ready            request handshake
//   req_a, req_b                     operands
//   req_sm2c_sel                     1 = sign-magnitude, 0 = 2's complement
//   req_addsub_sel                   0 = add, 1 = subtract
//   req_tag                          opaque tag returned with the result
//   as_a_out, as_b_out,
//   as_sm2c_sel_out,
//   as_addsub_sel_out                registered operands driven to the adder
//   as_sum_in, as_carry_in           adder result
//   res_valid / res_ready            result handshake
//   res_sum, res_carry               captured adder result
//   res_ovf, res_zero                derived flags
//   res_tag                          tag of the request that produced the result
//   op_cnt                           number of consumed results (wrapping)
// -----------------------------------------------------------------------------
module farc_addsub_seq #(
    parameter int ADDER_WIDTH = 32,
    parameter int ADD_LAT     = 1,
    parameter int TAG_WIDTH   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDER_WIDTH-1:0] req_a,
    input  logic [ADDER_WIDTH-1:0] req_b,
    input  logic                   req_sm2c_sel,
    input  logic                   req_addsub_sel,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic [ADDER_WIDTH-1:0] as_a_out,
    output logic [ADDER_WIDTH-1:0] as_b_out,
    output logic                   as_sm2c_sel_out,
    output logic                   as_addsub_sel_out,
    input  logic [ADDER_WIDTH-1:0] as_sum_in,
    input  logic                   as_carry_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ADDER_WIDTH-1:0] res_sum,
    output logic                   res_carry,
    output logic                   res_ovf,
    output logic                   res_zero,
    output logic [TAG_WIDTH-1:0]   res_tag,
    output logic [CNT_WIDTH-1:0]   op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]           LAT_INIT = 4'(ADD_LAT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [3:0]               lat_cnt_q, lat_cnt_d;
    logic                     req_ready_q, req_ready_d;
    logic                     res_valid_q, res_valid_d;
    logic [ADDER_WIDTH-1:0]   a_q, a_d;
    logic [ADDER_WIDTH-1:0]   b_q, b_d;
    logic                     sm2c_q, sm2c_d;
    logic                     addsub_q, addsub_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [ADDER_WIDTH-1:0]   sum_q, sum_d;
    logic                     carry_q, carry_d;
    logic                     ovf_q, ovf_d;
    logic                     zero_q, zero_d;
    logic [CNT_WIDTH-1:0]     op_cnt_q, op_cnt_d;

    // Overflow: in SM mode the adder carry is the magnitude overflow; in 2C
    // mode a sign change inconsistent with the operand signs is overflow.
    function automatic logic calc_ovf(input logic sa, input logic sb, input logic ss,
                                      input logic sm2c, input logic sub, input logic carry);
        logic ovf;
        if (sm2c) begin
            ovf = carry;
        end else if (sub) begin
            ovf = (sa != sb) && (ss != sa);
        end else begin
            ovf = (sa == sb) && (ss != sa);
        end
        return ovf;
    endfunction

    // Zero: SM mode ignores the sign bit so negative zero also reads as zero.
    function automatic logic calc_zero(input logic [ADDER_WIDTH-1:0] sum, input logic sm2c);
        logic zero;
        if (sm2c) begin
            zero = (sum[ADDER_WIDTH-2:0] == '0);
        end else begin
            zero = (sum == '0);
        end
        return zero;
    endfunction

    // Next-state, datapath capture and handshake flag computation.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sm2c_d      = sm2c_q;
        addsub_d    = addsub_q;
        tag_d       = tag_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        op_cnt_d    = op_cnt_q;
        case (state_q)
            IDLE: begin
                // req_ready_q gates acceptance so nothing is taken on the
                // first edge after reset release.
                if (req_valid && req_ready_q) begin
                    a_d       = req_a;
                    b_d       = req_b;
                    sm2c_d    = req_sm2c_sel;
                    addsub_d  = req_addsub_sel;
                    tag_d     = req_tag;
                    lat_cnt_d = LAT_INIT;
                    state_d   = EXEC;
                end else begin
                    state_d   = IDLE;
                end
            end
            EXEC: begin
                if (lat_cnt_q == 4'd1) begin
                    sum_d   = as_sum_in;
                    carry_d = as_carry_in;
                    ovf_d   = calc_ovf(a_q[ADDER_WIDTH-1], b_q[ADDER_WIDTH-1],
                                       as_sum_in[ADDER_WIDTH-1], sm2c_q, addsub_q,
                                       as_carry_in);
                    zero_d  = calc_zero(as_sum_in, sm2c_q);
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    op_cnt_d = op_cnt_q + CNT_ONE;
                    state_d  = IDLE;
                end else begin
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
    end

    // State, operand, result and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 4'd0;
            req_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sm2c_q      <= 1'b0;
            addsub_q    <= 1'b0;
            tag_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sm2c_q      <= sm2c_d;
            addsub_q    <= addsub_d;
            tag_q       <= tag_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign res_valid         = res_valid_q;
    assign as_a_out          = a_q;
    assign as_b_out          = b_q;
    assign as_sm2c_sel_out   = sm2c_q;
    assign as_addsub_sel_out = addsub_q;
    assign res_sum           = sum_q;
    assign res_carry         = carry_q;
    assign res_ovf           = ovf_q;
    assign res_zero          = zero_q;
    assign res_tag           = tag_q;
    assign op_cnt            = op_cnt_q;

endmodule

// File: tb/tb_farc_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_farc_addsub_seq
// Two instances: d=0 (ADDER_WIDTH=8, ADD_LAT=1, CNT_WIDTH=2) and
// d=1 (ADDER_WIDTH=8, ADD_LAT=3, CNT_WIDTH=16), each with a behavioural
// ripple adder/subtractor on its as_* ports. Expected results are pushed to a
// per-instance queue at request time and popped when res_valid appears.
// -----------------------------------------------------------------------------
module tb_farc_addsub_seq;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
        logic       zero;
        logic [3:0] tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       req_valid [2];
    logic       req_ready [2];
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_sm;
    logic       req_sub;
    logic [3:0] req_tag;
    logic [7:0] as_a      [2];
    logic [7:0] as_b      [2];
    logic       as_sm     [2];
    logic       as_sub    [2];
    logic [7:0] as_sum    [2];
    logic       as_carry  [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic [7:0] res_sum   [2];
    logic       res_carry [2];
    logic       res_ovf   [2];
    logic       res_zero  [2];
    logic [3:0] res_tag   [2];
    logic [1:0]  op_cnt0;
    logic [15:0] op_cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   cnt_m [2];
    int   n_cmp;
    int   n_err;

    // Behavioural adder: returns {carry, sum}.
    function automatic logic [8:0] adder_f(input logic [7:0] a, input logic [7:0] b,
                                           input logic sm, input logic sub);
        logic [8:0] r;
        logic [7:0] m;
        logic       sa, sb;
        if (!sm) begin
            r = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {8'd0, sub};
        end else begin
            sa = a[7];
            sb = b[7] ^ sub;
            if (sa == sb) begin
                m = {1'b0, a[6:0]} + {1'b0, b[6:0]};
                r = {m[7], sa, m[6:0]};
            end else if (a[6:0] >= b[6:0]) begin
                r = {1'b0, sa, a[6:0] - b[6:0]};
            end else begin
                r = {1'b0, sb, b[6:0] - a[6:0]};
            end
        end
        return r;
    endfunction

    assign {as_carry[0], as_sum[0]} = adder_f(as_a[0], as_b[0], as_sm[0], as_sub[0]);
    assign {as_carry[1], as_sum[1]} = adder_f(as_a[1], as_b[1], as_sm[1], as_sub[1]);

    farc_addsub_seq #(.ADDER_WIDTH(8), .ADD_LAT(1), .TAG_WIDTH(4), .CNT_WIDTH(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a(req_a), .req_b(req_b), .req_sm2c_sel(req_sm), .req_addsub_sel(req_sub),
        .req_tag(req_tag),
        .as_a_out(as_a[0]), .as_b_out(as_b[0]),
        .as_sm2c_sel_out(as_sm[0]), .as_addsub_sel_out(as_sub[0]),
        .as_sum_in(as_sum[0]), .as_carry_in(as_carry[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_sum(res_sum[0]), .res_carry(res_carry[0]), .res_ovf(res_ovf[0]),
        .res_zero(res_zero[0]), .res_tag(res_tag[0]), .op_cnt(op_cnt0)
    );

    farc_addsub_seq #(.ADDER_WIDTH(8), .ADD_LAT(3), .TAG_WIDTH(4), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a(req_a), .req_b(req_b), .req_sm2c_sel(req_sm), .req_addsub_sel(req_sub),
        .req_tag(req_tag),
        .as_a_out(as_a[1]), .as_b_out(as_b[1]),
        .as_sm2c_sel_out(as_sm[1]), .as_addsub_sel_out(as_sub[1]),
        .as_sum_in(as_sum[1]), .as_carry_in(as_carry[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_sum(res_sum[1]), .res_carry(res_carry[1]), .res_ovf(res_ovf[1]),
        .res_zero(res_zero[1]), .res_tag(res_tag[1]), .op_cnt(op_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference for 2's complement: overflow from the true signed result.
    function automatic exp_t m2c(input logic [7:0] a, input logic [7:0] b,
                                 input logic sub, input logic [3:0] tag);
        exp_t e;
        int   s;
        int   u;
        if (sub) begin
            s       = int'($signed(a)) - int'($signed(b));
            u       = int'(a) - int'(b);
            e.carry = (a >= b);
        end else begin
            s       = int'($signed(a)) + int'($signed(b));
            u       = int'(a) + int'(b);
            e.carry = (u > 255);
        end
        e.sum  = u[7:0];
        e.ovf  = (s > 127) || (s < -128);
        e.zero = (e.sum == 8'd0);
        e.tag  = tag;
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] sum, input logic c, input logic o,
                                input logic z, input logic [3:0] tag);
        exp_t e;
        e.sum = sum; e.carry = c; e.ovf = o; e.zero = z; e.tag = tag;
        return e;
    endfunction

    function automatic logic [15:0] cnt_obs(input int d);
        return (d == 0) ? {14'd0, op_cnt0} : op_cnt1;
    endfunction

    task automatic chk_res(input int d, input exp_t x, input string pfx);
        chk({pfx, "_valid"}, 32'(res_valid[d]), 32'd1);
        chk({pfx, "_sum"},   32'(res_sum[d]),   32'(x.sum));
        chk({pfx, "_carry"}, 32'(res_carry[d]), 32'(x.carry));
        chk({pfx, "_ovf"},   32'(res_ovf[d]),   32'(x.ovf));
        chk({pfx, "_zero"},  32'(res_zero[d]),  32'(x.zero));
        chk({pfx, "_tag"},   32'(res_tag[d]),   32'(x.tag));
    endtask

    // One full operation, entered and left at a negedge. With hold=1 a new
    // request (~a, tag+1) is presented during the stall and stays pending.
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input logic sub, input logic [3:0] tag,
                          input exp_t e, input int lat, input int stall, input logic hold);
        int   n;
        int   c;
        exp_t x;
        req_a = a; req_b = b; req_sm = sm; req_sub = sub; req_tag = tag;
        req_valid[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("acc_wait", 32'(n), 32'd0);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        req_valid[d] = 1'b0;
        chk("as_a",   32'(as_a[d]),   32'(a));
        chk("as_b",   32'(as_b[d]),   32'(b));
        chk("as_sm",  32'(as_sm[d]),  32'(sm));
        chk("as_sub", 32'(as_sub[d]), 32'(sub));
        c = 0;
        while (!res_valid[d] && c < 40) begin
            chk("rdy_busy", 32'(req_ready[d]), 32'd0);
            @(negedge clk);
            c++;
            chk("as_hold", 32'(as_a[d]), 32'(a));
        end
        chk("latency", 32'(c), 32'(lat));
        if (d == 0) x = q0.pop_front(); else x = q1.pop_front();
        if (hold) begin
            req_a = ~a; req_tag = tag + 4'd1; req_valid[d] = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            chk_res(d, x, "stall");
            chk("stall_rdy", 32'(req_ready[d]), 32'd0);
            chk("stall_as",  32'(as_a[d]), 32'(a));
            @(negedge clk);
        end
        chk_res(d, x, "res");
        res_ready[d] = 1'b1;
        @(negedge clk);
        res_ready[d] = 1'b0;
        cnt_m[d]++;
        chk("op_cnt", 32'(cnt_obs(d)), (d == 0) ? 32'(cnt_m[d] % 4) : 32'(cnt_m[d] % 65536));
        chk("post_valid", 32'(res_valid[d]), 32'd0);
        chk("post_rdy",   32'(req_ready[d]), 32'd1);
        chk("post_as",    32'(as_a[d]), 32'(a));
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        cnt_m[0] = 0; cnt_m[1] = 0;
        rst = 1'b1;
        req_a = 8'd0; req_b = 8'd0; req_sm = 1'b0; req_sub = 1'b0; req_tag = 4'd0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            res_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdy",   32'(req_ready[i]), 32'd0);
            chk("rst_valid", 32'(res_valid[i]), 32'd0);
            chk("rst_as_a",  32'(as_a[i]),      32'd0);
            chk("rst_sum",   32'(res_sum[i]),   32'd0);
            chk("rst_cnt",   32'(cnt_obs(i)),   32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rdy0", 32'(req_ready[0]), 32'd1);
        chk("rel_rdy1", 32'(req_ready[1]), 32'd1);

        // 2C add overflow, then 2C subtract to zero.
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 4'd3, m2c(8'h7F, 8'h01, 1'b0, 4'd3), 1, 0, 1'b0);
        run_op(0, 8'h05, 8'h05, 1'b0, 1'b1, 4'd4, m2c(8'h05, 8'h05, 1'b1, 4'd4), 1, 0, 1'b0);
        // SM negative zero: -0 + +0.
        run_op(0, 8'h80, 8'h00, 1'b1, 1'b0, 4'd5, mk(8'h80, 1'b0, 1'b0, 1'b1, 4'd5), 1, 0, 1'b0);
        // SM magnitude overflow with 5 cycles of backpressure and a held request.
        run_op(0, 8'h70, 8'h20, 1'b1, 1'b0, 4'd6, mk(8'h10, 1'b1, 1'b1, 1'b0, 4'd6), 1, 5, 1'b1);
        // The held request: -15 + 32 in SM.
        run_op(0, 8'h8F, 8'h20, 1'b1, 1'b0, 4'd7, mk(8'h11, 1'b0, 1'b0, 1'b0, 4'd7), 1, 0, 1'b0);
        chk("wrap_cnt", 32'(op_cnt0), 32'd1);

        // Three-cycle settle instance.
        run_op(1, 8'h40, 8'h40, 1'b0, 1'b0, 4'd1, m2c(8'h40, 8'h40, 1'b0, 4'd1), 3, 0, 1'b0);
        run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 4'd2, m2c(8'hFF, 8'h01, 1'b0, 4'd2), 3, 2, 1'b0);

        // Reset one cycle into EXEC discards the operation.
        req_a = 8'h12; req_b = 8'h34; req_sm = 1'b0; req_sub = 1'b0; req_tag = 4'd9;
        req_valid[1] = 1'b1;
        chk("mid_acc_rdy", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("mid_as_a", 32'(as_a[1]), 32'h12);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy",   32'(req_ready[1]), 32'd0);
        chk("mid_rst_valid", 32'(res_valid[1]), 32'd0);
        rst = 1'b0;
        cnt_m[0] = 0; cnt_m[1] = 0;
        @(negedge clk);
        chk("mid_rel_rdy", 32'(req_ready[1]), 32'd1);
        chk("mid_cnt",     32'(op_cnt1), 32'd0);
        chk("mid_as_clr",  32'(as_a[1]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_res", 32'(res_valid[1]), 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
